// File: rtl/usr_pkg.sv
// Shared definitions for the Universal Shift Register family: op-codes and serial bit order.
package usr_pkg;

    localparam logic [1:0] NO_OPERATIONS      = 2'h0;
    localparam logic [1:0] SHIFT_DATA_LEFT    = 2'h1;
    localparam logic [1:0] SHIFT_DATA_RIGHT   = 2'h2;
    localparam logic [1:0] LOAD_PARALLEL_DATA = 2'h3;

    typedef enum logic {
        SHIFT_DIR_MSB_FIRST = 1'b0,
        SHIFT_DIR_LSB_FIRST = 1'b1
    } shift_dir_e;

endpackage

// File: rtl/word_holding_register.sv
// One-entry valid/ready output buffer; a load that finds it full and not draining is dropped and flagged.
module word_holding_register #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ready,
    input  logic                  clear_error,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  overrun
);

    logic accept;
    logic load_ok;
    logic drop;

    // Loading while the held word leaves this cycle lets words stream back to back.
    assign accept  = valid && ready;
    assign load_ok = load && (!valid || ready);
    assign drop    = load && !load_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load_ok) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (accept) begin
                valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_error) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/usr_serial_word_receiver.sv
// Rebuilds parallel words from the serial stream of a Universal Shift Register and
// presents them on a valid/ready port.
module usr_serial_word_receiver
    import usr_pkg::*;
#(
    parameter  int DATA_WIDTH  = 16,
    localparam int COUNT_WIDTH = $clog2(DATA_WIDTH + 1)
) (
    input  logic                   Clk_In,
    input  logic                   Reset_n_In,
    input  logic                   Enable_In,
    input  logic                   Shift_Direction_In,
    input  logic                   Frame_Start_In,
    input  logic                   Serial_Data_In,
    input  logic                   Serial_Valid_In,
    output logic [DATA_WIDTH-1:0]  Parallel_Data_Out,
    output logic                   Parallel_Valid_Out,
    input  logic                   Parallel_Ready_In,
    output logic [COUNT_WIDTH-1:0] Bit_Count_Out,
    output logic                   Overrun_Error_Out,
    input  logic                   Clear_Error_In
);

    localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0]  asm_q, asm_next, asm_base, shifted;
    logic [COUNT_WIDTH-1:0] count_q, count_next;
    shift_dir_e             dir_q, dir_next, dir_bit;
    logic                   take;
    logic                   word_done;

    always_comb begin
        take       = Enable_In && Serial_Valid_In;
        // Bit order is decided by the first bit of a word and then held for the rest of it.
        dir_bit    = ((count_q == '0) || Frame_Start_In) ? shift_dir_e'(Shift_Direction_In) : dir_q;
        asm_base   = Frame_Start_In ? '0 : asm_q;
        shifted    = (dir_bit == SHIFT_DIR_MSB_FIRST) ? {asm_base[DATA_WIDTH-2:0], Serial_Data_In}
                                                      : {Serial_Data_In, asm_base[DATA_WIDTH-1:1]};
        asm_next   = asm_q;
        count_next = count_q;
        dir_next   = dir_q;
        word_done  = 1'b0;
        if (take) begin
            asm_next = shifted;
            dir_next = dir_bit;
            if (Frame_Start_In) begin
                count_next = COUNT_WIDTH'(1);
            end else if (count_q == LAST_BIT) begin
                count_next = '0;
                word_done  = 1'b1;
            end else begin
                count_next = count_q + 1'b1;
            end
        end else if (Frame_Start_In) begin
            asm_next   = '0;
            count_next = '0;
        end
    end

    always_ff @(posedge Clk_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            asm_q   <= '0;
            count_q <= '0;
            dir_q   <= SHIFT_DIR_MSB_FIRST;
        end else begin
            asm_q   <= asm_next;
            count_q <= count_next;
            dir_q   <= dir_next;
        end
    end

    assign Bit_Count_Out = count_q;

    // The completed word is taken from the next-state value so it appears one cycle after its last bit.
    word_holding_register #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hold (
        .clk         (Clk_In),
        .rst_n       (Reset_n_In),
        .load        (word_done),
        .load_data   (asm_next),
        .ready       (Parallel_Ready_In),
        .clear_error (Clear_Error_In),
        .data        (Parallel_Data_Out),
        .valid       (Parallel_Valid_Out),
        .overrun     (Overrun_Error_Out)
    );

endmodule

// File: tb/tb_usr_serial_word_receiver.sv
// Bench for usr_serial_word_receiver: directed loopback scenarios plus random traffic against a bit-queue model.
module tb_usr_serial_word_receiver;
    import usr_pkg::*;

    localparam int W  = 16;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, dir, fs, sdata, svalid, rdy, clr;
    logic [W-1:0]  pdata;
    logic          pvalid, ovr;
    logic [CW-1:0] bcount;

    usr_serial_word_receiver #(.DATA_WIDTH(W)) dut (
        .Clk_In             (clk),
        .Reset_n_In         (rst_n),
        .Enable_In          (en),
        .Shift_Direction_In (dir),
        .Frame_Start_In     (fs),
        .Serial_Data_In     (sdata),
        .Serial_Valid_In    (svalid),
        .Parallel_Data_Out  (pdata),
        .Parallel_Valid_Out (pvalid),
        .Parallel_Ready_In  (rdy),
        .Bit_Count_Out      (bcount),
        .Overrun_Error_Out  (ovr),
        .Clear_Error_In     (clr)
    );

    always #5 clk = ~clk;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic [W-1:0]  exp_q[$];
    logic          m_bits[$];
    logic          m_dir;
    logic          m_full;
    logic          m_ovr;
    logic [W-1:0]  last_word;
    int unsigned   words_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] bits_to_word(input logic lsb_first);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (lsb_first) w[i] = m_bits[i];
            else           w[W-1-i] = m_bits[i];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        exp_q.delete();
        m_dir  = 1'b0;
        m_full = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // Reference: bits collected into a queue; a full queue becomes one word for a one-slot output.
    task automatic model_edge(input logic b, input logic v, input logic e, input logic f,
                              input logic d, input logic r, input logic c);
        logic         done, accept, drop;
        logic [W-1:0] w;
        done   = 1'b0;
        drop   = 1'b0;
        w      = '0;
        accept = m_full && r;
        if (e && v) begin
            if (f) begin
                m_bits.delete();
                m_dir = d;
            end else if (m_bits.size() == 0) begin
                m_dir = d;
            end
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                w = bits_to_word(m_dir);
                m_bits.delete();
                done = 1'b1;
            end
        end else if (f) begin
            m_bits.delete();
        end
        if (done) begin
            if (!m_full || accept) begin
                exp_q.push_back(w);
                m_full = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (accept) begin
            m_full = 1'b0;
        end
        if (drop)   m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
    endtask

    task automatic step(input logic b, input logic v, input logic e, input logic f,
                        input logic d, input logic r, input logic c);
        sdata = b; svalid = v; en = e; fs = f; dir = d; rdy = r; clr = c;
        @(posedge clk);
        model_edge(b, v, e, f, d, r, c);
        #1;
        check("bit_count", 32'(bcount), 32'(m_bits.size()));
        check("valid", 32'(pvalid), 32'(m_full));
        check("overrun", 32'(ovr), 32'(m_ovr));
        if (m_full && exp_q.size() != 0) check("held_data", 32'(pdata), 32'(exp_q[0]));
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, r, 1'b0);
    endtask

    // Behavioural USR: load the word, then shift it out on the side selected by the op-code.
    task automatic usr_frame(input logic [W-1:0] word, input logic [1:0] op, input logic r);
        logic [W-1:0] sr;
        logic         b;
        sr = word;
        for (int i = 0; i < W; i++) begin
            b = (op == SHIFT_DATA_LEFT) ? sr[W-1] : sr[0];
            step(b, 1'b1, 1'b1, 1'b0, (op == SHIFT_DATA_RIGHT), r, 1'b0);
            sr = (op == SHIFT_DATA_LEFT) ? (sr << 1) : (sr >> 1);
        end
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_data"}, 32'(pdata), 32'h0);
        check({tag, "_valid"}, 32'(pvalid), 32'h0);
        check({tag, "_count"}, 32'(bcount), 32'h0);
        check({tag, "_overrun"}, 32'(ovr), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: a word is consumed at the edge following a negedge where valid && ready.
    always @(negedge clk) begin
        if (rst_n && pvalid && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h, expected none", pdata);
            end else begin
                check("word", 32'(pdata), 32'(exp_q.pop_front()));
            end
            last_word = pdata;
            words_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] w;
        int unsigned  base;
        rst_n = 1'b0;
        sdata = 0; svalid = 0; en = 0; fs = 0; dir = 0; rdy = 0; clr = 0;
        model_reset();
        #23;
        check("rst_data", 32'(pdata), 32'h0);
        check("rst_valid", 32'(pvalid), 32'h0);
        check("rst_count", 32'(bcount), 32'h0);
        check("rst_overrun", 32'(ovr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: MSB-first loopback
        base = words_seen;
        usr_frame(16'hA5C3, SHIFT_DATA_LEFT, 1'b1);
        check("t1_valid_after_last_bit", 32'(pvalid), 32'h1);
        idle(3, 1'b1);
        check("t1_word", 32'(last_word), 32'hA5C3);
        check("t1_count", words_seen - base, 1);
        check("t1_overrun", 32'(ovr), 32'h0);

        // 2: LSB-first loopback
        usr_frame(16'h1E0F, SHIFT_DATA_RIGHT, 1'b1);
        idle(3, 1'b1);
        check("t2_word", 32'(last_word), 32'h1E0F);

        // 3: back-to-back frames, no gap
        base = words_seen;
        usr_frame(16'hFFFF, SHIFT_DATA_LEFT, 1'b1);
        usr_frame(16'h0001, SHIFT_DATA_LEFT, 1'b1);
        idle(3, 1'b1);
        check("t3_words", words_seen - base, 2);
        check("t3_last", 32'(last_word), 32'h0001);
        check("t3_overrun", 32'(ovr), 32'h0);

        // 4: overrun under backpressure, then drain and clear
        usr_frame(16'h1234, SHIFT_DATA_LEFT, 1'b0);
        usr_frame(16'h5678, SHIFT_DATA_LEFT, 1'b0);
        check("t4_held", 32'(pdata), 32'h1234);
        check("t4_overrun", 32'(ovr), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_accepted", 32'(last_word), 32'h1234);
        check("t4_valid_fell", 32'(pvalid), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_cleared", 32'(ovr), 32'h0);

        // 5: partial word, resync, enable gaps
        base = words_seen;
        for (int i = 0; i < 7; i++) step(1'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        w = 16'hBEEF;
        step(w[15], 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 14; i >= 0; i--) begin
            if (i == 12 || i == 8 || i == 3) step(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            step(w[i], 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        idle(3, 1'b1);
        check("t5_words", words_seen - base, 1);
        check("t5_word", 32'(last_word), 32'hBEEF);

        // 6: async reset mid-word and with a word held
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_count9", 32'(bcount), 32'd9);
        async_reset_check("t6_midword");
        usr_frame(16'h4242, SHIFT_DATA_LEFT, 1'b0);
        async_reset_check("t6_held");
        base = words_seen;
        usr_frame(16'h8001, SHIFT_DATA_LEFT, 1'b1);
        idle(3, 1'b1);
        check("t6_words", words_seen - base, 1);
        check("t6_word", 32'(last_word), 32'h8001);

        // Random traffic: gaps, disables, resyncs, direction wiggle, random backpressure
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 99) < 2), 1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0));
        end
        idle(4, 1'b1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
